// File: rtl/mux_pkg.sv
// Shared types and constants for the registered channel multiplexer.
package mux_pkg;
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} mux_state_t;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;
endpackage

// File: rtl/scan_counter.sv
// Channel/dwell counter for scan mode. ch is the channel of the sample being
// captured this cycle, i.e. the post-clear/post-advance counter value.
module scan_counter #(
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int DWELL_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               advance,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   ch
);
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic [DWELL_W-1:0] dw_q, dw_d;

  always_comb begin
    ch_d = ch_q;
    dw_d = dw_q;
    if (clear) begin
      ch_d = '0;
      dw_d = '0;
    end else if (advance) begin
      // >= so a dwell shrunk below the running count still moves on
      if (dw_q >= dwell) begin
        dw_d = '0;
        ch_d = (ch_q == SEL_W'(CHANNELS - 1)) ? '0 : ch_q + SEL_W'(1);
      end else begin
        dw_d = dw_q + DWELL_W'(1);
      end
    end
  end

  assign ch = ch_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q <= '0;
      dw_q <= '0;
    end else begin
      ch_q <= ch_d;
      dw_q <= dw_d;
    end
  end
endmodule

// File: rtl/mux_sel_reg.sv
// Registered N:1 channel multiplexer with direct/scan modes and a
// valid/ready output slot.
module mux_sel_reg
  import mux_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int DWELL_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      mode,
  input  logic [DWELL_W-1:0]        dwell,
  input  logic                      enable,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_err,
  output logic                      out_valid,
  input  logic                      out_ready
);
  mux_state_t       state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_err_q, out_err_d;
  logic             out_valid_q, out_valid_d;

  logic             free, accept, cnt_clear, cnt_adv, oor;
  logic [SEL_W-1:0] scan_ch, pick_idx;
  logic [WIDTH-1:0] pick_data;

  assign free   = !out_valid_q || out_ready;
  assign accept = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    if (free) begin
      if (!enable)                state_d = IDLE;
      else if (mode == MODE_SCAN) state_d = SCAN;
      else                        state_d = DIRECT;
    end
  end

  // Counters restart whenever scan is entered from another state.
  assign cnt_clear = free && (state_d == SCAN) && (state_q != SCAN);
  assign cnt_adv   = accept && (state_q == SCAN);

  scan_counter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W),
    .DWELL_W  (DWELL_W)
  ) u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear),
    .advance (cnt_adv),
    .dwell   (dwell),
    .ch      (scan_ch)
  );

  assign pick_idx = (state_d == SCAN) ? scan_ch : sel_in;
  assign oor      = int'(sel_in) >= CHANNELS;

  // Out-of-range indices match no channel and yield zero.
  always_comb begin
    pick_data = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (int'(pick_idx) == k) pick_data = data_in[k*WIDTH +: WIDTH];
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    if (free) begin
      unique case (state_d)
        DIRECT: begin
          out_data_d  = pick_data;
          out_ch_d    = sel_in;
          out_err_d   = oor;
          out_valid_d = 1'b1;
        end
        SCAN: begin
          out_data_d  = pick_data;
          out_ch_d    = scan_ch;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
        end
        default: out_valid_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_mux_sel_reg.sv
// Bench for mux_sel_reg: directed vector table, scan/reset/out-of-range
// sequences, then randomized traffic against a behavioural model.
module tb_mux_sel_reg;
  localparam int W  = 4;
  localparam int CH = 8;
  localparam int SW = 3;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [CH*W-1:0] data_in;
  logic [6*W-1:0]  data6;
  logic [SW-1:0]   sel_in;
  logic            mode, enable, out_ready;
  logic [DW-1:0]   dwell;

  logic [W-1:0]  a_data, b_data;
  logic [SW-1:0] a_ch, b_ch;
  logic          a_err, b_err, a_valid, b_valid;

  assign data6 = data_in[6*W-1:0];

  mux_sel_reg #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .DWELL_W(DW)) dut8 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .sel_in(sel_in), .mode(mode),
    .dwell(dwell), .enable(enable), .out_data(a_data), .out_ch(a_ch),
    .out_err(a_err), .out_valid(a_valid), .out_ready(out_ready));

  mux_sel_reg #(.WIDTH(W), .CHANNELS(6), .SEL_W(SW), .DWELL_W(DW)) dut6 (
    .clk(clk), .rst_n(rst_n), .data_in(data6), .sel_in(sel_in), .mode(mode),
    .dwell(dwell), .enable(enable), .out_data(b_data), .out_ch(b_ch),
    .out_err(b_err), .out_valid(b_valid), .out_ready(out_ready));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic chk_a(input string nm, input int v, input int d, input int c, input int e);
    chk({nm, " valid"}, int'(a_valid), v);
    chk({nm, " data"},  int'(a_data),  d);
    chk({nm, " ch"},    int'(a_ch),    c);
    chk({nm, " err"},   int'(a_err),   e);
  endtask

  typedef struct {
    int sel, md, en, rdy, dw;
    int vld, data, ch;
  } vec_t;
  vec_t tbl[$];

  task automatic addv(input int sel, md, en, rdy, dw, vld, data, ch);
    vec_t v;
    v = '{sel, md, en, rdy, dw, vld, data, ch};
    tbl.push_back(v);
  endtask

  task automatic load_ramp();
    for (int k = 0; k < CH; k++) data_in[k*W +: W] = W'(k + 3);
  endtask

  // Behavioural model: a scan run is the k-th sample since scan was entered;
  // its channel is (k / (dwell+1)) mod CH.
  int m_valid, m_data, m_ch, m_err, m_scan, m_k;

  task automatic model_edge();
    if (!m_valid || out_ready) begin
      if (!enable) begin
        m_valid = 0; m_scan = 0;
      end else if (!mode) begin
        m_valid = 1; m_ch = int'(sel_in); m_err = 0; m_scan = 0;
        m_data = int'(data_in[m_ch*W +: W]);
      end else begin
        m_k = m_scan ? m_k + 1 : 0;
        m_scan = 1; m_valid = 1; m_err = 0;
        m_ch = (m_k / (int'(dwell) + 1)) % CH;
        m_data = int'(data_in[m_ch*W +: W]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; sel_in = '0; mode = 1'b0; enable = 1'b0; out_ready = 1'b0;
    dwell = '0; data_in = '0;
    #2;
    chk_a("reset", 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    load_ramp();

    @(posedge clk); #1;
    chk_a("idle after release", 0, 0, 0, 0);

    addv(5, 0, 1, 1, 0, 1, 8, 5);
    for (int k = 0; k < CH; k++) addv(k, 0, 1, 1, 0, 1, k + 3, k);
    addv(2, 0, 1, 1, 0, 1, 5, 2);
    addv(6, 0, 1, 0, 0, 1, 5, 2);
    addv(6, 0, 1, 0, 0, 1, 5, 2);
    addv(6, 0, 1, 1, 0, 1, 9, 6);
    addv(6, 0, 0, 0, 0, 1, 9, 6);
    addv(6, 0, 0, 1, 0, 0, 9, 6);
    for (int k = 0; k < 5; k++) addv(0, 1, 1, 1, 0, 1, k + 3, k);
    addv(1, 0, 1, 1, 0, 1, 4, 1);
    addv(1, 1, 1, 1, 0, 1, 3, 0);
    addv(1, 1, 1, 1, 0, 1, 4, 1);
    addv(1, 0, 0, 1, 0, 0, 4, 1);

    foreach (tbl[i]) begin
      sel_in = SW'(tbl[i].sel); mode = tbl[i].md[0]; enable = tbl[i].en[0];
      out_ready = tbl[i].rdy[0]; dwell = DW'(tbl[i].dw);
      @(posedge clk); #1;
      chk_a($sformatf("vec%0d", i), tbl[i].vld, tbl[i].data, tbl[i].ch, 0);
    end

    // Scan wrap with dwell=2: 0,0,0,1,1,1,...,7,7,7,0
    mode = 1'b1; enable = 1'b1; out_ready = 1'b1; dwell = DW'(2);
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      chk_a($sformatf("scan%0d", i), 1, (i / 3) % CH + 3, (i / 3) % CH, 0);
    end

    // Asynchronous reset in the middle of a cycle with a sample pending
    #2 rst_n = 1'b0;
    #1 chk_a("async reset", 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_a("held in reset", 0, 0, 0, 0);
    rst_n = 1'b1;

    // Out-of-range select on the 6-channel instance
    mode = 1'b0; enable = 1'b1; out_ready = 1'b1; sel_in = SW'(7);
    @(posedge clk); #1;
    chk("oor valid", int'(b_valid), 1);
    chk("oor data",  int'(b_data),  0);
    chk("oor err",   int'(b_err),   1);
    chk("oor ch",    int'(b_ch),    7);
    sel_in = SW'(3);
    @(posedge clk); #1;
    chk("inrange data", int'(b_data), 6);
    chk("inrange err",  int'(b_err),  0);
    chk("inrange ch",   int'(b_ch),   3);

    // Randomized traffic against the model
    rst_n = 1'b0; enable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_valid = 0; m_data = 0; m_ch = 0; m_err = 0; m_scan = 0; m_k = 0;
    dwell = DW'(1); mode = 1'b0;
    for (int i = 0; i < 400; i++) begin
      data_in   = $urandom;
      sel_in    = SW'($urandom_range(0, CH - 1));
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      enable    = ($urandom_range(0, 7) != 0);
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      model_edge();
      #1;
      chk_a($sformatf("rnd%0d", i), m_valid, m_data, m_ch, m_err);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
